// File: rtl/imu_sensor_regfile.sv
// imu_sensor_regfile
// Avalon-MM slave register file for the IMU subsystem.
// Collects NUM_IN sensor result channels with new-data and overrun flags
// and an optional coherent snapshot (FREEZE). Exposes NUM_OUT host-written
// channels with one-cycle write strobes, and raises a registered level
// interrupt.
//
// Word address map (S = NUM_IN + NUM_OUT):
//   0 .. NUM_IN-1   input channel data (RO; snapshot while FREEZE=1)
//   NUM_IN .. S-1   output channel data (RW)
//   S               STATUS   new-data bitmask (RO)
//   S+1             CTRL     bit0 FREEZE, bit1 IRQ_EN (RW)
//   S+2             OVERRUN  overrun bitmask (write-1-to-clear)
//   others          read 0, writes ignored
// NUM_IN + NUM_OUT + 3 must not exceed 2**ADDR_W.

module imu_sensor_regfile #(
    parameter int NUM_IN  = 10,
    parameter int NUM_OUT = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      chipselect,
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      read,
    input  logic                      write,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_valid,
    output logic                      irq
);

    localparam int S = NUM_IN + NUM_OUT;

    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(S);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(S + 1);
    localparam logic [ADDR_W-1:0] A_OVERRUN = ADDR_W'(S + 2);

    // Zero-extend a channel value to the 32-bit Avalon data bus.
    function automatic logic [31:0] zext_data(input logic [DATA_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[DATA_W-1:0] = v;
        return r;
    endfunction

    // Zero-pad a per-input-channel bitmask to the 32-bit Avalon data bus.
    function automatic logic [31:0] zext_mask(input logic [NUM_IN-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_IN-1:0] = v;
        return r;
    endfunction

    // Channel storage and flags
    logic [DATA_W-1:0] live [NUM_IN];
    logic [DATA_W-1:0] snap [NUM_IN];
    logic [NUM_IN-1:0] new_flag;
    logic [NUM_IN-1:0] ovr;
    logic              freeze;
    logic              irq_en;

    // Decoded access controls
    logic               rd_en;
    logic               wr_en;
    logic [NUM_IN-1:0]  in_sel;
    logic [NUM_OUT-1:0] out_sel;
    logic               ctrl_wr;
    logic [NUM_IN-1:0]  rd_clr;
    logic [NUM_IN-1:0]  ovr_clr;
    logic [31:0]        rd_mux;

    // Address decode; chipselect gates both read and write.
    always_comb begin
        rd_en   = chipselect & read;
        wr_en   = chipselect & write;
        in_sel  = '0;
        out_sel = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            in_sel[k] = (addr == ADDR_W'(k));
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            out_sel[j] = (addr == ADDR_W'(NUM_IN + j));
        end
        ctrl_wr = wr_en && (addr == A_CTRL);
        rd_clr  = rd_en ? in_sel : '0;
        ovr_clr = (wr_en && (addr == A_OVERRUN)) ? writedata[NUM_IN-1:0] : '0;
    end

    // Read data mux over pre-edge register state; unmapped addresses give 0.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel[k]) begin
                rd_mux = zext_data(freeze ? snap[k] : live[k]);
            end
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (out_sel[j]) begin
                rd_mux = zext_data(out_data[j*DATA_W +: DATA_W]);
            end
        end
        if (addr == A_STATUS) begin
            rd_mux = zext_mask(new_flag);
        end
        if (addr == A_CTRL) begin
            rd_mux = {30'd0, irq_en, freeze};
        end
        if (addr == A_OVERRUN) begin
            rd_mux = zext_mask(ovr);
        end
    end

    // Live channel capture on each channel's valid strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_IN; k++) begin
                live[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (in_valid[k]) begin
                    live[k] <= in_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Snapshot all live channels only on a FREEZE 0->1 transition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_IN; k++) begin
                snap[k] <= '0;
            end
        end else if (ctrl_wr && writedata[0] && !freeze) begin
            for (int k = 0; k < NUM_IN; k++) begin
                snap[k] <= live[k];
            end
        end
    end

    // CTRL register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            freeze <= 1'b0;
            irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            freeze <= writedata[0];
            irq_en <= writedata[1];
        end
    end

    // New-data and overrun flags; a same-cycle set always beats a clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            new_flag <= '0;
            ovr      <= '0;
        end else begin
            new_flag <= in_valid | (new_flag & ~rd_clr);
            ovr      <= (in_valid & new_flag) | (ovr & ~ovr_clr);
        end
    end

    // Host-written output channels with a one-cycle strobe per write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            out_valid <= wr_en ? out_sel : '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                if (wr_en && out_sel[j]) begin
                    out_data[j*DATA_W +: DATA_W] <= writedata[DATA_W-1:0];
                end
            end
        end
    end

    // Registered read data; holds its value when no read is sampled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

    // Registered interrupt, one cycle behind the new-data flags and IRQ_EN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & (|new_flag);
        end
    end

endmodule

// File: tb/tb_imu_sensor_regfile.sv
// Scoreboard bench for imu_sensor_regfile: stimulus pushes expected read
// data and output-channel strobes into queues; monitors pop and compare
// whenever the DUT presents a result.

module tb_imu_sensor_regfile;

    localparam int NUM_IN  = 10;
    localparam int NUM_OUT = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int A_STATUS  = NUM_IN + NUM_OUT;
    localparam int A_CTRL    = A_STATUS + 1;
    localparam int A_OVERRUN = A_STATUS + 2;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      chipselect;
    logic [ADDR_W-1:0]         addr;
    logic                      read;
    logic                      write;
    logic [31:0]               writedata;
    logic [31:0]               readdata;
    logic [NUM_IN*DATA_W-1:0]  in_data;
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_OUT-1:0]        out_valid;
    logic                      irq;

    imu_sensor_regfile #(
        .NUM_IN (NUM_IN),
        .NUM_OUT(NUM_OUT),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chipselect(chipselect),
        .addr      (addr),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        logic [NUM_OUT-1:0] vld;
        int                 ch;
        logic [31:0]        data;
    } out_exp_t;

    rd_exp_t  rd_q[$];
    out_exp_t out_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Read-data monitor: one result per sampled chipselect&read.
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= chipselect & read & reset_n;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_read", readdata, 32'hxxxx_xxxx);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk(e.name, readdata, e.data);
            end
        end
    end

    // Output-channel monitor: every out_valid pulse must be expected.
    always @(negedge clk) begin
        if (out_valid != '0) begin
            if (out_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                out_exp_t o;
                o = out_q.pop_front();
                chk("out_valid", 32'(out_valid), 32'(o.vld));
                chk("out_data", out_data[o.ch*DATA_W +: DATA_W], o.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.data = exp;
        rd_q.push_back(e);
        chipselect = 1'b1; read = 1'b1; addr = ADDR_W'(a);
        tick();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        if (a >= NUM_IN && a < NUM_IN + NUM_OUT) begin
            out_exp_t o;
            o.vld = NUM_OUT'(1) << (a - NUM_IN);
            o.ch = a - NUM_IN;
            o.data = d;
            out_q.push_back(o);
        end
        chipselect = 1'b1; write = 1'b1; addr = ADDR_W'(a); writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic strobe(input int k, input logic [31:0] d);
        in_valid[k] = 1'b1;
        in_data[k*DATA_W +: DATA_W] = d;
        tick();
        in_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; writedata = '0; in_data = '0; in_valid = '0;
        tick(); tick();
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // Every address reads zero after reset, including unmapped ones.
        for (int a = 0; a < 32; a++) rd(a, 32'd0, $sformatf("reset_rd_%0d", a));

        // Channel 3 capture, STATUS before and after the clearing read.
        strobe(3, 32'h1234);
        rd(A_STATUS, 32'h8, "status_ch3_set");
        rd(3, 32'h1234, "rd_ch3");
        rd(A_STATUS, 32'h0, "status_ch3_clr");

        // FREEZE: frozen reads return the snapshot; live keeps updating.
        strobe(0, 32'h5555);
        wr(A_CTRL, 32'h1);
        strobe(0, 32'hAAAA);                  // new[0] already set -> ovr[0]
        rd(0, 32'h5555, "frozen_ch0");
        rd(A_CTRL, 32'h1, "ctrl_freeze");
        wr(A_CTRL, 32'h0);
        rd(0, 32'hAAAA, "unfrozen_ch0");
        wr(A_CTRL, 32'h1);                    // snapshot 0xAAAA
        strobe(0, 32'hBBBB);
        wr(A_CTRL, 32'h1);                    // already frozen: no re-snapshot
        rd(0, 32'hAAAA, "no_resnap_ch0");
        wr(A_CTRL, 32'h0);
        rd(A_OVERRUN, 32'h1, "ovr_ch0");
        wr(A_OVERRUN, 32'h1);

        // Overrun on channel 5 and write-1-to-clear.
        strobe(5, 32'h11);
        strobe(5, 32'h22);
        rd(A_OVERRUN, 32'h20, "ovr_ch5_set");
        wr(A_OVERRUN, 32'h20);
        rd(A_OVERRUN, 32'h0, "ovr_ch5_clr");

        // Same-cycle strobe and read of 5: old value returned, new[5] stays.
        in_valid[5] = 1'b1; in_data[5*DATA_W +: DATA_W] = 32'h33;
        rd(5, 32'h22, "same_cycle_rd5");
        in_valid = '0;
        rd(A_STATUS, 32'h20, "status_set_wins");
        rd(5, 32'h33, "rd5_after");
        rd(A_STATUS, 32'h0, "status_after_rd5");
        wr(A_OVERRUN, 32'h20);

        // Same-cycle overrun set and clear: set wins.
        strobe(5, 32'h44);
        in_valid[5] = 1'b1; in_data[5*DATA_W +: DATA_W] = 32'h55;
        wr(A_OVERRUN, 32'h20);
        in_valid = '0;
        rd(A_OVERRUN, 32'h20, "ovr_set_wins");
        wr(A_OVERRUN, 32'h20);
        rd(A_OVERRUN, 32'h0, "ovr_clr2");
        rd(5, 32'h55, "rd5_final");

        // Output channels.
        wr(NUM_IN + 1, 32'hDEADBEEF);
        rd(NUM_IN + 1, 32'hDEADBEEF, "rd_out1");
        wr(NUM_IN + 0, 32'h01234567);
        rd(NUM_IN + 0, 32'h01234567, "rd_out0");

        // chipselect low: write ignored, readdata holds.
        chipselect = 1'b0; write = 1'b1; read = 1'b1; addr = ADDR_W'(NUM_IN + 2);
        writedata = 32'hFFFF_FFFF;
        tick();
        write = 1'b0; read = 1'b0;
        chk("readdata_hold", readdata, 32'h01234567);
        rd(NUM_IN + 2, 32'h0, "rd_out2_untouched");

        // Read and write in the same cycle: old value read, write performed.
        begin
            rd_exp_t e;
            out_exp_t o;
            e.name = "rdwr_old"; e.data = 32'h01234567; rd_q.push_back(e);
            o.vld = 3'b001; o.ch = 0; o.data = 32'hCAFE0000; out_q.push_back(o);
            chipselect = 1'b1; read = 1'b1; write = 1'b1;
            addr = ADDR_W'(NUM_IN); writedata = 32'hCAFE0000;
            tick();
            chipselect = 1'b0; read = 1'b0; write = 1'b0;
        end
        rd(NUM_IN, 32'hCAFE0000, "rdwr_new");

        // Interrupt.
        wr(A_CTRL, 32'h2);
        rd(A_CTRL, 32'h2, "ctrl_irq_en");
        chk("irq_idle", 32'(irq), 32'd0);
        strobe(9, 32'h99);
        chk("irq_lag", 32'(irq), 32'd0);
        tick();
        chk("irq_rise", 32'(irq), 32'd1);
        rd(9, 32'h99, "rd_ch9");
        chk("irq_still_high", 32'(irq), 32'd1);
        tick();
        chk("irq_fall", 32'(irq), 32'd0);
        strobe(9, 32'h9A);
        tick();
        chk("irq_rise2", 32'(irq), 32'd1);

        // Reset in the middle of a write: aborted, no strobe.
        reset_n = 1'b0;
        chipselect = 1'b1; write = 1'b1; addr = ADDR_W'(NUM_IN + 2);
        writedata = 32'h1111_2222;
        tick();
        chipselect = 1'b0; write = 1'b0;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_out_data", out_data[1*DATA_W +: DATA_W], 32'd0);
        reset_n = 1'b1;
        tick();
        rd(9, 32'h0, "post_rst_ch9");
        rd(A_CTRL, 32'h0, "post_rst_ctrl");
        rd(A_STATUS, 32'h0, "post_rst_status");
        rd(NUM_IN + 2, 32'h0, "post_rst_out2");
        tick(); tick();

        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("out_queue_drained", 32'(out_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/imu_sensor_regfile.md
# imu_sensor_regfile

Parametrised Avalon-MM slave register file for the IMU subsystem. It collects NUM_IN sensor result channels (gyro, depth, magnetometer, accelerometer-degree, and future additions) and exposes NUM_OUT host-writable channels back to the sensor datapath. Compared with the fixed IMU register map, it adds:
- per-channel new-data and overrun flags,
- a coherent multi-channel snapshot (freeze),
- a registered interrupt,
- write strobes on the output channels.

It sits between the Nios Avalon fabric and the sensor/processing modules.

## Interface
- NUM_IN, 10, sensor input channels (1..32)
- NUM_OUT, 3, host-written output channels (1..8)
- DATA_W, 32, channel width (8..32)
- ADDR_W, 5, Avalon word-address width; requires NUM_IN+NUM_OUT+3 <= 2^ADDR_W
- clk  in  1  single clock for all logic (Avalon and sensor side)
- reset_n  in  1  synchronous, active-low reset
- chipselect  in  1  Avalon select
- addr  in  ADDR_W  word address
- read  in  1  read request
- write  in  1  write request
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_data  in  NUM_IN*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- in_valid  in  NUM_IN  one-cycle strobe per channel; captures in_data slice
- out_data  out  NUM_OUT*DATA_W  host-written channels, same packing
- out_valid  out  NUM_OUT  one-cycle pulse when channel rewritten
- irq  out  1  level interrupt

## Operation
- Address map. Let S = NUM_IN+NUM_OUT.
  - 0..NUM_IN-1: input channel data (RO).
  - NUM_IN..S-1: output channels (RW).
  - S: STATUS, new-data bitmask, RO.
  - S+1: CTRL. Bit0 FREEZE, bit1 IRQ_EN, RW.
  - S+2: OVERRUN bitmask, write-1-to-clear.
  - All other addresses read 0; writes to them are ignored.
- Live registers: when in_valid[k] is high, live[k] takes in_data slice k at that edge.
- FREEZE:
  - A CTRL write that sets FREEZE from 0 to 1 copies every live[k] into snap[k] at that edge.
  - While FREEZE=1, input-channel reads return snap[k]; live[k] keeps updating.
  - While FREEZE=0, reads return live[k].
  - Writing FREEZE=1 while it is already 1 does not re-snapshot.
- Readback width: input values are zero-extended from DATA_W to 32 bits.
- new[k]:
  - Set by in_valid[k].
  - Cleared by an Avalon read of address k.
  - If in_valid[k] and the read of k occur in the same cycle, set wins and new[k] stays 1.
- ovr[k]:
  - Set when in_valid[k] arrives while new[k]=1.
  - Cleared by writing 1 to bit k of OVERRUN.
  - If set and clear occur in the same cycle, set wins.
- Output channels: a write to NUM_IN+j loads writedata[DATA_W-1:0] into out_data slice j, and out_valid[j] pulses high for exactly one cycle.
- Interrupt: irq is registered, irq <= IRQ_EN & (|new).
- STATUS and OVERRUN read back zero-padded above bit NUM_IN-1.
- chipselect low: read and write are ignored.
- read and write both high: both are performed.

## Timing
- Reset (reset_n low at posedge clk), all of the following go to 0:
  - readdata, out_data, out_valid, irq
  - live, snap, new, ovr
  - CTRL
- Reset mid-transaction aborts it; no out_valid pulse is issued.
- Read latency is 1 cycle: readdata is valid the cycle after chipselect&read is sampled. readdata holds its last value otherwise.
- A read returns register state from before the same edge's updates. Example: in_valid[k] and a read of k in one cycle returns the old live[k].
- Write latency: out_data and out_valid update on the edge that samples the write. CTRL takes effect for reads issued the following cycle.
- Snapshot capture uses live values from before any same-edge in_valid update.
- irq lags the change of new/IRQ_EN by 1 cycle.
- No wait states; every access completes in one cycle.

## Test plan
- Reset, then read every mapped address -> all return 0; irq=0, out_valid=0.
- in_valid[3] with in_data ch3=0x1234, then read addr 3 -> readdata 0x1234 one cycle later; STATUS bit3 is 1 before the read and 0 after.
- Write CTRL=1 (freeze), then in_valid[0] with 0xAAAA -> read addr 0 returns the pre-freeze value; write CTRL=0 -> read returns 0xAAAA.
- Two in_valid[5] strobes with no read in between -> OVERRUN bit5=1; write 0x20 to OVERRUN -> reads 0. Same-cycle in_valid[5] and read of 5 -> new[5] remains 1.
- Write 0xDEADBEEF to addr NUM_IN+1 -> out_data ch1=0xDEADBEEF and out_valid=3'b010 for exactly one cycle; read back returns 0xDEADBEEF.
- CTRL=2 (IRQ_EN), in_valid[9] -> irq rises one cycle later; read addr 9 -> irq falls one cycle after new clears. Assert reset_n low mid-sequence -> irq=0 at the next edge.
